// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst command front end driving a single-port RAM
// Optional macro RAM_BURST_CHK_EN: reject bursts that would run past the last address.
module ram_burst_ctrl #(
  parameter int P_DATA_WIDTH = 4,
  parameter int P_ADDR_DEPTH = 128,
  localparam int AW = $clog2(P_ADDR_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_wr,
  input  logic [AW-1:0]           i_cmd_addr,
  input  logic [AW-1:0]           i_cmd_len,
  input  logic [P_DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  output logic [P_DATA_WIDTH-1:0] o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_rd_ready,
  output logic                    o_ram_ena,
  output logic                    o_ram_wea,
  output logic [AW-1:0]           o_ram_addr,
  output logic [P_DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [P_DATA_WIDTH-1:0] i_ram_rdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(P_ADDR_DEPTH - 1);
  localparam logic [AW:0]   ONE_BEAT  = (AW+1)'(1);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW:0]   beats;
  logic [AW-1:0] addr_next;
  logic          cmd_fire;
  logic          wr_fire;
  logic          rd_issue;
  logic          rd_take;
  logic          chk_fail;

  assign cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign wr_fire   = o_wr_ready & i_wr_valid;
  // A read is only issued when the output register is free or being drained this cycle.
  assign rd_issue  = (state == S_READ) && (beats != '0) && (!o_rd_valid || i_rd_ready);
  assign rd_take   = o_rd_valid & i_rd_ready;
  assign addr_next = (addr == LAST_ADDR) ? '0 : addr + AW'(1);

  assign o_ram_ena   = wr_fire | rd_issue;
  assign o_ram_wea   = wr_fire;
  assign o_ram_addr  = addr;
  assign o_ram_wdata = wr_fire ? i_wr_data : '0;

`ifdef RAM_BURST_CHK_EN
  logic [AW:0] end_addr;

  assign end_addr = {1'b0, i_cmd_addr} + {1'b0, i_cmd_len};
  assign chk_fail = end_addr > {1'b0, LAST_ADDR};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else begin
      o_err <= cmd_fire & chk_fail;
    end
  end
`else
  assign chk_fail = 1'b0;
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      beats       <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_done      <= 1'b0;
      o_wr_ready  <= 1'b0;
      o_busy      <= 1'b0;
      o_cmd_ready <= 1'b1;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire && !chk_fail) begin
            addr        <= i_cmd_addr;
            beats       <= {1'b0, i_cmd_len} + ONE_BEAT;
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            o_wr_ready  <= i_cmd_wr;
            state       <= i_cmd_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            addr  <= addr_next;
            beats <= beats - ONE_BEAT;
            if (beats == ONE_BEAT) begin
              o_wr_ready <= 1'b0;
              o_done     <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (rd_issue) begin
            o_rd_data  <= i_ram_rdata;
            o_rd_valid <= 1'b1;
            addr       <= addr_next;
            beats      <= beats - ONE_BEAT;
          end else if (rd_take) begin
            o_rd_valid <= 1'b0;
            // Completion waits for the final beat to leave the output register.
            if (beats == '0) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          o_busy      <= 1'b0;
          o_cmd_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - scoreboard bench for ram_burst_ctrl with a behavioural RAM
module tb_ram_burst_ctrl;

  localparam int DW    = 4;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [AW-1:0] i_cmd_addr, i_cmd_len;
  logic [DW-1:0] i_wr_data;
  logic          i_wr_valid, o_wr_ready;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid, i_rd_ready;
  logic          o_ram_ena, o_ram_wea;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata, i_ram_rdata;
  logic          o_busy, o_done, o_err;

  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  logic [DW-1:0] vec [8];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_evt_cyc = 0;
  int rd_issues = 0;

  logic [AW+DW-1:0] exp_wr [$];
  logic [DW-1:0]    exp_rd [$];
  int               exp_done [$];
  logic [AW+DW-1:0] mon_e;
  logic [DW-1:0]    mon_d;
  logic             prev_stall = 1'b0;
  logic [DW-1:0]    prev_data = '0;

  ram_burst_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_ram_ena(o_ram_ena), .o_ram_wea(o_ram_wea), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) if (o_ram_ena && o_ram_wea) mem[o_ram_addr] <= o_ram_wdata;

  assign i_ram_rdata = mem[o_ram_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want nothing", nm, act);
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("rd_hold", 32'({o_rd_valid, o_rd_data}), 32'({1'b1, prev_data}));
      if (o_rd_valid && !i_rd_ready) check("stall_no_ena", 32'(o_ram_ena), 32'd0);
      if (o_ram_ena && o_ram_wea) begin
        if (exp_wr.size() == 0) fail_now("unexp_wr", 32'({o_ram_addr, o_ram_wdata}));
        else begin
          mon_e = exp_wr.pop_front();
          check("wr_beat", 32'({o_ram_addr, o_ram_wdata}), 32'(mon_e));
        end
        last_evt_cyc = cyc;
      end
      if (o_ram_ena && !o_ram_wea) rd_issues++;
      if (o_rd_valid && i_rd_ready) begin
        if (exp_rd.size() == 0) fail_now("unexp_rd", 32'(o_rd_data));
        else begin
          mon_d = exp_rd.pop_front();
          check("rd_beat", 32'(o_rd_data), 32'(mon_d));
        end
        last_evt_cyc = cyc;
      end
      if (o_done) begin
        if (exp_done.size() == 0) fail_now("unexp_done", 32'(cyc));
        else begin
          void'(exp_done.pop_front());
          check("done_lat", 32'(cyc), 32'(last_evt_cyc + 1));
        end
      end
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len);
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_wr    = wr;
    i_cmd_addr  = a;
    i_cmd_len   = len;
    while (!o_cmd_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("cmd_ready", 32'(o_cmd_ready), 32'd1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic drive_write(input int beats, output int cycles);
    int k = 0;
    int n = 0;
    logic rdy;
    while (k < beats && n < 50) begin
      i_wr_valid = 1'b1;
      i_wr_data  = vec[k];
      @(negedge i_clk);
      rdy = o_wr_ready;
      @(posedge i_clk); #1;
      n++;
      if (rdy) k++;
    end
    i_wr_valid = 1'b0;
    cycles = n;
    check("wr_beats", 32'(k), 32'(beats));
  endtask

  task automatic drive_read(input int beats, input logic [15:0] mask, output int cycles);
    int h = 0;
    int n = 0;
    while (h < beats && n < 60) begin
      i_rd_ready = !mask[n % 16];
      @(negedge i_clk);
      if (o_rd_valid && i_rd_ready) h++;
      @(posedge i_clk); #1;
      n++;
    end
    i_rd_ready = 1'b0;
    cycles = n;
    check("rd_beats", 32'(h), 32'(beats));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int cyc_n;
    int issues0;
    i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wr_data = '0; i_wr_valid = 1'b0; i_rd_ready = 1'b0;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_busy", 32'({o_busy, o_done, o_err}), 32'd0);
    check("rst_rd", 32'({o_rd_valid, o_rd_data}), 32'd0);
    check("rst_ram", 32'({o_ram_ena, o_ram_wea, o_wr_ready}), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // write 5..8 back to back
    vec[0] = 4'd1; vec[1] = 4'd2; vec[2] = 4'd3; vec[3] = 4'd4;
    exp_wr.push_back({7'd5, 4'd1}); exp_wr.push_back({7'd6, 4'd2});
    exp_wr.push_back({7'd7, 4'd3}); exp_wr.push_back({7'd8, 4'd4});
    exp_done.push_back(1);
    send_cmd(1'b1, 7'd5, 7'd3);
    drive_write(4, cyc_n);
    check("t1_cycles", 32'(cyc_n), 32'd4);
    wait_idle();

    // read 5..8 with ready held high
    exp_rd.push_back(4'd1); exp_rd.push_back(4'd2); exp_rd.push_back(4'd3); exp_rd.push_back(4'd4);
    exp_done.push_back(1);
    send_cmd(1'b0, 7'd5, 7'd3);
    drive_read(4, 16'h0000, cyc_n);
    check("t2_cycles", 32'(cyc_n), 32'd5);
    wait_idle();

    // read 5..8 with ready low for two cycles mid-burst
    exp_rd.push_back(4'd1); exp_rd.push_back(4'd2); exp_rd.push_back(4'd3); exp_rd.push_back(4'd4);
    exp_done.push_back(1);
    issues0 = rd_issues;
    send_cmd(1'b0, 7'd5, 7'd3);
    drive_read(4, 16'h0018, cyc_n);
    check("t3_cycles", 32'(cyc_n), 32'd7);
    wait_idle();
    check("t3_issues", 32'(rd_issues - issues0), 32'd4);

    // write across the top of the address space
    vec[0] = 4'd9; vec[1] = 4'd10; vec[2] = 4'd11; vec[3] = 4'd12;
`ifdef RAM_BURST_CHK_EN
    send_cmd(1'b1, 7'd126, 7'd3);
    check("t4_err_pulse", 32'({o_err, o_busy, o_cmd_ready}), 32'b101);
    @(posedge i_clk); #1;
    check("t4_err_clear", 32'(o_err), 32'd0);
    check("t4_mem126", 32'(mem[126]), 32'd0);
`else
    exp_wr.push_back({7'd126, 4'd9}); exp_wr.push_back({7'd127, 4'd10});
    exp_wr.push_back({7'd0, 4'd11});  exp_wr.push_back({7'd1, 4'd12});
    exp_done.push_back(1);
    send_cmd(1'b1, 7'd126, 7'd3);
    check("t4_no_err", 32'(o_err), 32'd0);
    drive_write(4, cyc_n);
    check("t4_cycles", 32'(cyc_n), 32'd4);
    wait_idle();
    exp_rd.push_back(4'd9); exp_rd.push_back(4'd10); exp_rd.push_back(4'd11); exp_rd.push_back(4'd12);
    exp_done.push_back(1);
    send_cmd(1'b0, 7'd126, 7'd3);
    drive_read(4, 16'h0000, cyc_n);
    check("t4_rd_cycles", 32'(cyc_n), 32'd5);
    wait_idle();
`endif

    // write data offered while idle must be ignored
    i_wr_valid = 1'b1;
    i_wr_data  = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("idle_wr_ignored", 32'({o_ram_ena, o_wr_ready}), 32'd0);
      @(posedge i_clk); #1;
    end
    i_wr_valid = 1'b0;

    // a second command held during a busy burst must be ignored
    vec[0] = 4'd5; vec[1] = 4'd6;
    exp_wr.push_back({7'd20, 4'd5}); exp_wr.push_back({7'd21, 4'd6});
    exp_done.push_back(1);
    send_cmd(1'b1, 7'd20, 7'd1);
    issues0 = rd_issues;
    i_cmd_valid = 1'b1; i_cmd_wr = 1'b0; i_cmd_addr = 7'd0; i_cmd_len = 7'd0;
    drive_write(2, cyc_n);
    i_cmd_valid = 1'b0;
    check("t5_cycles", 32'(cyc_n), 32'd2);
    wait_idle();
    repeat (3) begin @(posedge i_clk); #1; end
    check("t5_no_read", 32'(rd_issues - issues0), 32'd0);
    check("t5_rd_valid", 32'(o_rd_valid), 32'd0);

    // reset in the middle of a len 7 write
    exp_wr.push_back({7'd40, 4'd1}); exp_wr.push_back({7'd41, 4'd2});
    send_cmd(1'b1, 7'd40, 7'd7);
    i_wr_valid = 1'b1; i_wr_data = 4'd1;
    @(posedge i_clk); #1;
    i_wr_data = 4'd2;
    @(posedge i_clk); #1;
    i_wr_data = 4'd3;
    i_rst = 1'b1;
    #1;
    check("t6_ena_off", 32'({o_ram_ena, o_ram_wea, o_wr_ready}), 32'd0);
    check("t6_cmd_ready", 32'({o_cmd_ready, o_busy}), 32'b10);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_wr_valid = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    check("t6_idle", 32'({o_cmd_ready, o_busy}), 32'b10);
    check("t6_mem42", 32'(mem[42]), 32'd0);

    check("wr_q_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd.size()), 32'd0);
    check("done_q_empty", 32'(exp_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
